// File: rtl/instr_fetch_unit.sv
// PC / instruction-register stage in front of instr_memory: sequences fetches, hands
// instructions to decode over valid/ready, takes redirects and traps bad PCs.
module instr_fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] TEXT_BASE  = 32'h0040_0000,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
    parameter int unsigned           MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rd,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc_next;
    logic [ADDR_WIDTH-1:0]   cand_pc;
    logic [ADDR_WIDTH-1:0]   cand_word;
    logic                    cand_bad;
    logic                    load_pc;
    logic                    instr_load;

    // imem_addr and pc_plus4 are pure functions of the pc register
    assign imem_addr = (pc - TEXT_BASE) >> 2;
    assign pc_plus4  = pc + ADDR_WIDTH'(4);

    // Next-state logic; a new pc is range-checked before it is loaded
    always_comb begin
        state_next = state;
        pc_next    = pc;
        cand_pc    = pc + ADDR_WIDTH'(4);
        load_pc    = 1'b0;
        instr_load = 1'b0;
        cand_word  = '0;
        cand_bad   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    cand_pc = redirect_pc;
                    load_pc = 1'b1;
                end else begin
                    instr_load = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    cand_pc = redirect_pc;
                    load_pc = 1'b1;
                end else if (instr_ready) begin
                    load_pc = 1'b1;
                end
            end
            default: begin
                state_next = FAULT;
            end
        endcase

        // A pc+4 wrap lands below TEXT_BASE and is caught by the lower-bound test
        cand_word = (cand_pc - TEXT_BASE) >> 2;
        cand_bad  = (cand_pc[1:0] != 2'b00) || (cand_pc < TEXT_BASE) ||
                    (cand_word >= ADDR_WIDTH'(MEM_WORDS));

        if (load_pc) begin
            pc_next    = cand_pc;
            state_next = cand_bad ? FAULT : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr_valid <= (state_next == VALID);
            fault       <= (state_next == FAULT);
            if (instr_load) begin
                instr <= imem_rd;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table for streaming/back-pressure plus
// hand sequences for redirect, fault, async reset and idle behaviour.
module tb_instr_fetch_unit;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] words [8];

    typedef struct {
        logic        start;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
    } vec_t;

    vec_t vecs [15];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: first 8 words from a table, beyond that a recognisable pattern
    always_comb begin
        if (imem_addr < 32'd8) imem_rd = words[imem_addr[2:0]];
        else                   imem_rd = {16'hA5A5, imem_addr[15:0]};
    end

    function automatic vec_t mk(logic s, logic r, logic rv, logic [31:0] rp,
                                logic ev, logic [31:0] ep, logic [31:0] ei, logic ef);
        vec_t v;
        v.start = s; v.ready = r; v.redir = rv; v.rpc = rp;
        v.e_valid = ev; v.e_pc = ep; v.e_instr = ei; v.e_fault = ef;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic check_out(string tag, logic ev, logic [31:0] ep, logic [31:0] ei, logic ef);
        check({tag, ".valid"}, 32'(instr_valid), 32'(ev));
        check({tag, ".pc"},    pc, ep);
        check({tag, ".instr"}, instr, ei);
        check({tag, ".fault"}, 32'(fault), 32'(ef));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic s, logic r, logic rv, logic [31:0] rp);
        start = s; instr_ready = r; redirect_valid = rv; redirect_pc = rp;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Reset, start, and stream until the VALID cycle holding word n
    task automatic run_to_valid(int n);
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            step();
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            step();
        end
    endtask

    initial begin
        words[0] = 32'h0050_0093; words[1] = 32'h0010_0113;
        words[2] = 32'h0020_81b3; words[3] = 32'h0000_006f;
        words[4] = 32'h0000_0013; words[5] = 32'h1111_1111;
        words[6] = 32'h2222_2222; words[7] = 32'h3333_3333;

        // Streaming with ready=1, then 5 cycles of back-pressure on word 3
        vecs[0]  = mk(1, 1, 0, 0, 0, 32'h0040_0000, 32'h0,         0);
        vecs[1]  = mk(0, 1, 0, 0, 1, 32'h0040_0000, 32'h0050_0093, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 32'h0040_0004, 32'h0050_0093, 0);
        vecs[3]  = mk(0, 1, 0, 0, 1, 32'h0040_0004, 32'h0010_0113, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 32'h0040_0008, 32'h0010_0113, 0);
        vecs[5]  = mk(0, 1, 0, 0, 1, 32'h0040_0008, 32'h0020_81b3, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 32'h0040_000C, 32'h0020_81b3, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 32'h0040_000C, 32'h0000_006f, 0);
        vecs[8]  = mk(0, 0, 0, 0, 1, 32'h0040_000C, 32'h0000_006f, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 32'h0040_000C, 32'h0000_006f, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 32'h0040_000C, 32'h0000_006f, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 32'h0040_000C, 32'h0000_006f, 0);
        vecs[12] = mk(0, 0, 0, 0, 1, 32'h0040_000C, 32'h0000_006f, 0);
        vecs[13] = mk(0, 1, 0, 0, 0, 32'h0040_0010, 32'h0000_006f, 0);
        vecs[14] = mk(0, 0, 0, 0, 1, 32'h0040_0010, 32'h0000_0013, 0);

        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        do_reset();
        check_out("reset", 1'b0, BASE, 32'h0, 1'b0);
        check("reset.imem_addr", imem_addr, 32'h0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].start, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                      vecs[i].e_instr, vecs[i].e_fault);
            check($sformatf("vec%0d.pc_plus4", i), pc_plus4, vecs[i].e_pc + 32'd4);
        end

        // Redirect together with the handshake at 0x00400004 skips word 2
        run_to_valid(1);
        check("redir_hs.pre_pc", pc, 32'h0040_0004);
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0010);
        step();
        check_out("redir_hs.fetch", 1'b0, 32'h0040_0010, 32'h0010_0113, 1'b0);
        check("redir_hs.imem_addr", imem_addr, 32'd4);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        check_out("redir_hs.valid", 1'b1, 32'h0040_0010, 32'h0000_0013, 1'b0);

        // Redirect while in FETCH discards the word under read
        run_to_valid(0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b1, 32'h0040_0008);
        step();
        check_out("redir_fetch", 1'b0, 32'h0040_0008, 32'h0050_0093, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_out("redir_fetch.valid", 1'b1, 32'h0040_0008, 32'h0020_81b3, 1'b0);

        // Misaligned redirect faults and the fault is sticky
        run_to_valid(0);
        drive(1'b0, 1'b0, 1'b1, 32'h0040_0006);
        step();
        check_out("misalign", 1'b0, 32'h0040_0006, 32'h0050_0093, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 32'h0040_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("sticky%0d", i), 1'b0, 32'h0040_0006, 32'h0050_0093, 1'b1);
        end

        // One past the last word faults
        run_to_valid(0);
        drive(1'b0, 1'b0, 1'b1, 32'h0040_1000);
        step();
        check_out("oor", 1'b0, 32'h0040_1000, 32'h0050_0093, 1'b1);

        // Last word is legal; stepping past it by pc+4 faults
        run_to_valid(0);
        drive(1'b0, 1'b0, 1'b1, 32'h0040_0FFC);
        step();
        check_out("last.fetch", 1'b0, 32'h0040_0FFC, 32'h0050_0093, 1'b0);
        check("last.imem_addr", imem_addr, 32'd1023);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_out("last.valid", 1'b1, 32'h0040_0FFC, 32'hA5A5_03FF, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        check_out("last.step", 1'b0, 32'h0040_1000, 32'hA5A5_03FF, 1'b1);

        // Below TEXT_BASE faults
        run_to_valid(0);
        drive(1'b0, 1'b0, 1'b1, 32'h003F_FFFC);
        step();
        check_out("below", 1'b0, 32'h003F_FFFC, 32'h0050_0093, 1'b1);

        // Asynchronous reset between edges while in FETCH
        run_to_valid(0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        check("arst.pre_pc", pc, 32'h0040_0004);
        #3 rst_n = 1'b0;
        #1;
        check_out("arst", 1'b0, BASE, 32'h0, 1'b0);
        check("arst.imem_addr", imem_addr, 32'h0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_out("arst.restart", 1'b1, BASE, 32'h0050_0093, 1'b0);

        // IDLE ignores redirects while start is low
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'(i % 2), 32'h0040_0006);
            step();
            check_out($sformatf("idle%0d", i), 1'b0, BASE, 32'h0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
